// File: rtl/alu_seq_param_pkg.sv
// rtl/alu_seq_param_pkg.sv - op codes and FSM state encoding for the sequential ALU
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - operand/result handshake bundle for the sequential ALU
interface alu_seq_param_if #(parameter int WIDTH = 4);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2:0]             op;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     x;
  logic                   zero;
  logic                   carry;
  logic                   ovf;
  logic                   busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, x, zero, carry, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, x, zero, carry, ovf, busy
  );

endinterface

// File: rtl/alu_seq_param_mul_iter.sv
// rtl/alu_seq_param_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] partial;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    partial  = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The final product is the combinational sum of the last step so the top can register it directly.
  assign done = run_q && (cnt_q == LAST);
  assign p    = partial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - registered 8-op ALU with in/out handshakes and iterative multiply
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_seq_param_if.slave  bus
);

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   x_q, x_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_p;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   res;
  logic                 res_c;
  logic                 res_v;

  assign bus.in_ready  = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign mul_start     = accept && (bus.op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res[WIDTH:0] = sum;
        res_c        = sum[WIDTH];
        res_v        = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      // The extra MSB of the widened difference is exactly the unsigned borrow.
      OP_SUB: begin
        res[WIDTH-1:0] = diff[WIDTH-1:0];
        res_c          = diff[WIDTH];
        res_v          = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL:  res = '0;
      OP_OR:   res[WIDTH-1:0] = bus.a | bus.b;
      OP_AND:  res[WIDTH-1:0] = bus.a & bus.b;
      OP_NOR:  res[WIDTH-1:0] = ~(bus.a | bus.b);
      OP_XOR:  res[WIDTH-1:0] = bus.a ^ bus.b;
      OP_NOTA: res[WIDTH-1:0] = ~bus.a;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            state_d     = S_MUL;
            out_valid_d = 1'b0;
          end else begin
            x_d         = res;
            zero_d      = (res == '0);
            carry_d     = res_c;
            ovf_d       = res_v;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          x_d         = mul_p;
          zero_d      = (mul_p == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - self-checking bench for alu_seq_param (WIDTH=4 model-checked, WIDTH=8 directed)
module tb_alu_seq_param;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   cyc;

  alu_seq_param_if #(.WIDTH(4)) bus  ();
  alu_seq_param_if #(.WIDTH(8)) bus8 ();

  alu_seq_param #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_seq_param #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] x;
    logic       z;
    logic       c;
    logic       v;
    bit         mul;
    int         rdy;
  } exp_t;

  // Reference for WIDTH=4, computed with plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int ai, bi, sa, sb, r, s;
    ai = int'(a);
    bi = int'(b);
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    r = 0; s = 0;
    e.c = 1'b0; e.v = 1'b0; e.mul = 1'b0; e.rdy = 0;
    case (op)
      3'd0: begin r = ai + bi; e.c = (r > 15); s = sa + sb; e.v = (s > 7) || (s < -8); end
      3'd1: begin r = (ai - bi + 16) % 16; e.c = (ai < bi); s = sa - sb; e.v = (s > 7) || (s < -8); end
      3'd2: begin r = ai * bi; e.mul = 1'b1; end
      3'd3: r = ai | bi;
      3'd4: r = ai & bi;
      3'd5: r = 15 - (ai | bi);
      3'd6: r = ai ^ bi;
      default: r = 15 - ai;
    endcase
    e.x = 8'(r);
    e.z = (r == 0);
    return e;
  endfunction

  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    bit ov_e, busy_e, ir_e;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_x", bus.x, 0);
      chk("rst_flags", {bus.zero, bus.carry, bus.ovf}, 0);
    end else begin
      ov_e   = (q.size() > 0) && (cyc >= q[0].rdy);
      busy_e = (q.size() > 0) && q[0].mul && (cyc < q[0].rdy);
      ir_e   = !busy_e && (!ov_e || bus.out_ready);
      chk("mdl_out_valid", bus.out_valid, ov_e);
      chk("mdl_busy", bus.busy, busy_e);
      chk("mdl_in_ready", bus.in_ready, ir_e);
      if (ov_e) begin
        chk("mdl_x", bus.x, q[0].x);
        chk("mdl_zcv", {bus.zero, bus.carry, bus.ovf}, {q[0].z, q[0].c, q[0].v});
        if (bus.out_ready) void'(q.pop_front());
      end
      if (bus.in_valid && ir_e) begin
        e = model(bus.op, bus.a, bus.b);
        e.rdy = cyc + 1 + (e.mul ? 4 : 0);
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic send(input logic [2:0] o, input logic [3:0] aa, input logic [3:0] bb);
    int n;
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a  = aa;
    bus.b  = bb;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 40), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("out_timeout", (lat < 30), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] x_tab [8];
    int lat;
    x_tab = '{8'h18, 8'h0E, 8'h8F, 8'h0F, 8'h09, 8'h00, 8'h06, 8'h04};
    n_chk = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // All eight ops on a=1011, b=1101
    for (int i = 0; i < 8; i++) begin
      send(3'(i), 4'b1011, 4'b1101);
      wait_out(lat);
      chk("t1_x", bus.x, x_tab[i]);
      chk("t1_latency", lat, (i == 2) ? 4 : 0);
      if (i < 2) chk("t1_carry", bus.carry, 1);
      if (i == 5) chk("t1_nor_zero", bus.zero, 1);
    end

    // Signed overflow on add and sub
    send(3'd0, 4'b0111, 4'b0001);
    wait_out(lat);
    chk("t2_add_x", bus.x, 8'h08);
    chk("t2_add_ovf", bus.ovf, 1);
    chk("t2_add_carry", bus.carry, 0);
    send(3'd1, 4'b1000, 4'b0001);
    wait_out(lat);
    chk("t2_sub_x", bus.x, 8'h07);
    chk("t2_sub_ovf", bus.ovf, 1);

    // Back-pressure: result frozen, no accept, then simultaneous drain/accept
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(3'd6, 4'd5, 4'd3);
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 4'd2; bus.b = 4'd3;
    repeat (5) begin
      @(negedge clk);
      chk("t3_in_ready", bus.in_ready, 0);
      chk("t3_out_valid", bus.out_valid, 1);
      chk("t3_x_held", bus.x, 8'h06);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_release", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t3_out_valid_kept", bus.out_valid, 1);
    chk("t3_x_next", bus.x, 8'h05);

    // Multiply stall with a pending op held on the input
    send(3'd2, 4'b1111, 4'b1111);
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 4'd1; bus.b = 4'd2;
    for (int i = 0; i < 4; i++) begin
      chk("t4_busy", bus.busy, 1);
      chk("t4_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    chk("t4_out_valid", bus.out_valid, 1);
    chk("t4_x", bus.x, 8'hE1);
    chk("t4_busy_done", bus.busy, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t4_next_x", bus.x, 8'h03);

    // Reset during the second multiply cycle
    send(3'd2, 4'd6, 4'd7);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_x", bus.x, 0);
    chk("t5_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t5_no_stale", bus.out_valid, 0);
    end

    // WIDTH=8 instance
    bus8.in_valid = 1'b1; bus8.op = 3'd2; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t6_mul_latency", lat, 8);
    chk("t6_mul_x", bus8.x, 16'hFE01);
    bus8.in_valid = 1'b1; bus8.op = 3'd0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    chk("t6_add_x", bus8.x, 16'h01FE);
    chk("t6_add_carry", bus8.carry, 1);
    chk("t6_add_ovf", bus8.ovf, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
